// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM front end: defaults, duty word type and
// register address-map helpers.
package pwm_pkg;

    localparam logic [15:0] DUTY_OFFSET         = 16'h098C;
    localparam int          DEF_TICK_DIV        = 32;
    localparam int          DEF_FRAME_TICKS     = 2500;

    typedef logic [15:0] duty_t;

    // Even address = low byte, odd address = high byte of channel addr/2.
    function automatic logic addr_is_hi(input logic [3:0] addr);
        return addr[0];
    endfunction

    function automatic logic [2:0] addr_ch(input logic [3:0] addr);
        return addr[3:1];
    endfunction

    function automatic logic addr_valid(input logic [3:0] addr, input int num_ch);
        return (int'(addr[3:1]) < num_ch);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Tick divider and frame counter; both strobes are decoded from the counters
// so they line up exactly with the wrap cycles.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS
) (
    input  logic clk,
    input  logic reset,
    output logic clk_tick,
    output logic pwmclk
);

    localparam int DW = $clog2(TICK_DIV);
    localparam int FW = $clog2(FRAME_TICKS + 1);

    logic [DW-1:0] div_q, div_d;
    logic [FW-1:0] frm_q, frm_d;
    logic          div_wrap, frm_wrap;

    always_comb begin
        div_wrap = (div_q == DW'(TICK_DIV - 1));
        frm_wrap = (frm_q == FW'(FRAME_TICKS - 1));
        div_d    = div_wrap ? '0 : div_q + 1'b1;
        frm_d    = frm_q;
        if (div_wrap) begin
            frm_d = frm_wrap ? '0 : frm_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= '0;
            frm_q <= '0;
        end else begin
            div_q <= div_d;
            frm_q <= frm_d;
        end
    end

    assign clk_tick = div_wrap;
    assign pwmclk   = div_wrap & frm_wrap;

endmodule

// File: rtl/pwm_frame_ctrl.sv
// Double-buffered duty register bank committed at frame boundaries.
// Optional watchdog failsafe enabled by defining PWM_FAILSAFE_EN.
module pwm_frame_ctrl
    import pwm_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int FRAME_TICKS = DEF_FRAME_TICKS,
    parameter int NUM_CH      = 4,
    parameter int WDOG_FRAMES = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [7:0]            wr_data,
    output logic                  clk_tick,
    output logic                  pwmclk,
    output logic [8*NUM_CH-1:0]   duty_lo,
    output logic [8*NUM_CH-1:0]   duty_hi,
    output logic [NUM_CH-1:0]     pending,
    output logic                  failsafe
);

    logic [2:0] wr_ch;
    logic       wr_lo, wr_hi, trip;

    pwm_timebase #(
        .TICK_DIV    (TICK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timebase (
        .clk      (clk),
        .reset    (reset),
        .clk_tick (clk_tick),
        .pwmclk   (pwmclk)
    );

    assign wr_ch = addr_ch(wr_addr);
    assign wr_lo = wr_en && addr_valid(wr_addr, NUM_CH) && !addr_is_hi(wr_addr);
    assign wr_hi = wr_en && addr_valid(wr_addr, NUM_CH) &&  addr_is_hi(wr_addr);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [7:0] stage_q, stage_d;
        duty_t      pword_q, pword_d;
        duty_t      active_q, active_d;
        logic       pend_q, pend_d;
        logic       sel;

        assign sel = (wr_ch == 3'(gi));

        // Commit reads the pre-write pending word; a write in the same cycle
        // re-arms pending for the following frame.
        always_comb begin
            stage_d  = stage_q;
            pword_d  = pword_q;
            active_d = active_q;
            pend_d   = pend_q;
            if (wr_lo && sel) stage_d = wr_data;
            if (pwmclk && pend_q) active_d = pword_q;
            if (trip) active_d = '0;
            if (pwmclk) pend_d = 1'b0;
            if (wr_hi && sel) begin
                pword_d = {wr_data, stage_q};
                pend_d  = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q  <= '0;
                pword_q  <= '0;
                active_q <= '0;
                pend_q   <= 1'b0;
            end else begin
                stage_q  <= stage_d;
                pword_q  <= pword_d;
                active_q <= active_d;
                pend_q   <= pend_d;
            end
        end

        assign duty_lo[8*gi +: 8] = active_q[7:0];
        assign duty_hi[8*gi +: 8] = active_q[15:8];
        assign pending[gi]        = pend_q;
    end

`ifdef PWM_FAILSAFE_EN
    localparam int WDW = $clog2(WDOG_FRAMES + 1);

    logic [WDW-1:0] wdog_q, wdog_d;
    logic           fs_q, fs_d;

    // Counter saturates at the limit so the trip fires once per silence period.
    always_comb begin
        wdog_d = wdog_q;
        fs_d   = fs_q;
        trip   = pwmclk && !wr_hi && (wdog_q == WDW'(WDOG_FRAMES - 1));
        if (wr_hi) begin
            wdog_d = '0;
            fs_d   = 1'b0;
        end else if (pwmclk && (wdog_q != WDW'(WDOG_FRAMES))) begin
            wdog_d = wdog_q + 1'b1;
        end
        if (trip) fs_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
            fs_q   <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            fs_q   <= fs_d;
        end
    end

    assign failsafe = fs_q;
`else
    assign trip     = 1'b0;
    assign failsafe = 1'b0;
`endif

endmodule

// File: tb/tb_pwm_frame_ctrl.sv
// Bench for pwm_frame_ctrl: directed steps plus random writes against a
// frame-level reference model; add PWM_FAILSAFE_EN to cover the watchdog.
module tb_pwm_frame_ctrl;

    localparam int TD  = 4;
    localparam int FT  = 10;
    localparam int NCH = 4;
    localparam int WD  = 3;
    localparam int P   = TD * FT;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 wr_en;
    logic [3:0]           wr_addr;
    logic [7:0]           wr_data;
    logic                 clk_tick, pwmclk, failsafe;
    logic [8*NCH-1:0]     duty_lo, duty_hi;
    logic [NCH-1:0]       pending;

    int total = 0;
    int bad   = 0;
    int unsigned cyc;

    logic [7:0]  m_stage [NCH];
    logic [15:0] m_pword [NCH];
    logic [15:0] m_act   [NCH];
    bit          m_pend  [NCH];
    int          m_wd;
    bit          m_fs;

    pwm_frame_ctrl #(
        .TICK_DIV    (TD),
        .FRAME_TICKS (FT),
        .NUM_CH      (NCH),
        .WDOG_FRAMES (WD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clk_tick (clk_tick),
        .pwmclk   (pwmclk),
        .duty_lo  (duty_lo),
        .duty_hi  (duty_hi),
        .pending  (pending),
        .failsafe (failsafe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NCH; i++) begin
            m_stage[i] = '0;
            m_pword[i] = '0;
            m_act[i]   = '0;
            m_pend[i]  = 1'b0;
        end
        m_wd = 0;
        m_fs = 1'b0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step(input bit we, input logic [3:0] a, input logic [7:0] d);
        bit pw, tk, valid, hi;
        int ch;
        logic [8*NCH-1:0] e_lo, e_hi;
        logic [NCH-1:0]   e_pend;
        wr_en   = we;
        wr_addr = a;
        wr_data = d;
        #1;
        tk = (cyc % TD) == TD - 1;
        pw = (cyc % P) == P - 1;
        chk("clk_tick", {31'b0, clk_tick}, {31'b0, tk});
        chk("pwmclk",   {31'b0, pwmclk},   {31'b0, pw});

        valid = we && (int'(a) < 2 * NCH);
        hi    = a[0];
        ch    = int'(a) / 2;
        if (pw) begin
            for (int i = 0; i < NCH; i++) begin
                if (m_pend[i]) begin
                    m_act[i]  = m_pword[i];
                    m_pend[i] = 1'b0;
                end
            end
        end
`ifdef PWM_FAILSAFE_EN
        if (valid && hi) begin
            m_wd = 0;
            m_fs = 1'b0;
        end else if (pw && m_wd < WD) begin
            m_wd++;
            if (m_wd == WD) begin
                for (int i = 0; i < NCH; i++) m_act[i] = '0;
                m_fs = 1'b1;
            end
        end
`endif
        if (valid) begin
            if (hi) begin
                m_pword[ch] = {d, m_stage[ch]};
                m_pend[ch]  = 1'b1;
            end else begin
                m_stage[ch] = d;
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        wr_en = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            e_lo[8*i +: 8] = m_act[i][7:0];
            e_hi[8*i +: 8] = m_act[i][15:8];
            e_pend[i]      = m_pend[i];
        end
        chk("duty_lo",  32'(duty_lo),  32'(e_lo));
        chk("duty_hi",  32'(duty_hi),  32'(e_hi));
        chk("pending",  32'(pending),  32'(e_pend));
        chk("failsafe", {31'b0, failsafe}, {31'b0, m_fs});
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'd0, 8'd0);
    endtask

    // Runs idle cycles up to and including the next frame-restart cycle.
    task automatic to_commit();
        bit p;
        for (int i = 0; i < P; i++) begin
            p = (cyc % P) == P - 1;
            step(1'b0, 4'd0, 8'd0);
            if (p) break;
        end
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        cyc     = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_duty_lo", 32'(duty_lo), 32'h0);
        chk("rst_duty_hi", 32'(duty_hi), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_strobes", {30'b0, clk_tick, pwmclk}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Timebase from reset release: ticks every 4, frames every 40.
        idle(85);

        // Deferred commit on channel 1.
        step(1'b1, 4'd2, 8'h34);
        step(1'b1, 4'd3, 8'h12);
        chk("def_pend1", {31'b0, pending[1]}, 32'h1);
        chk("def_hold",  32'(duty_hi[15:8]), 32'h0);
        to_commit();
        chk("def_lo1",   32'(duty_lo[15:8]), 32'h34);
        chk("def_hi1",   32'(duty_hi[15:8]), 32'h12);
        chk("def_pend1c", {31'b0, pending[1]}, 32'h0);

        // High-byte write landing exactly in the frame-restart cycle.
        step(1'b1, 4'd6, 8'h77);
        while ((cyc % P) != P - 1) step(1'b0, 4'd0, 8'd0);
        step(1'b1, 4'd7, 8'hAB);
        chk("bnd_pend3", {31'b0, pending[3]}, 32'h1);
        chk("bnd_hold3", 32'(duty_hi[31:24]), 32'h0);
        to_commit();
        chk("bnd_hi3", 32'(duty_hi[31:24]), 32'hAB);
        chk("bnd_lo3", 32'(duty_lo[31:24]), 32'h77);

        // Out-of-range address, then last high write wins.
        step(1'b1, 4'd9, 8'hEE);
        step(1'b1, 4'd8, 8'hDD);
        step(1'b1, 4'd0, 8'h55);
        step(1'b1, 4'd1, 8'h01);
        step(1'b1, 4'd1, 8'h02);
        to_commit();
        chk("lww_hi0", 32'(duty_hi[7:0]), 32'h02);
        chk("lww_lo0", 32'(duty_lo[7:0]), 32'h55);

        // Random byte writes including invalid addresses.
        for (int i = 0; i < 200; i++) begin
            step(($urandom % 3) == 0, 4'($urandom % 10), 8'($urandom));
        end

`ifdef PWM_FAILSAFE_EN
        step(1'b1, 4'd0, 8'h00);
        step(1'b1, 4'd1, 8'h10);
        to_commit();
        chk("fs_commit", 32'(duty_hi[7:0]), 32'h10);
        to_commit();
        chk("fs_wait", {31'b0, failsafe}, 32'h0);
        to_commit();
        chk("fs_trip",  {31'b0, failsafe}, 32'h1);
        chk("fs_zero",  32'(duty_hi | duty_lo), 32'h0);
        step(1'b1, 4'd3, 8'h22);
        chk("fs_clear", {31'b0, failsafe}, 32'h0);
`endif

        // Asynchronous reset mid-frame with live and pending data.
        step(1'b1, 4'd4, 8'h00);
        step(1'b1, 4'd5, 8'h05);
        to_commit();
        chk("ar_act2", {16'h0, duty_hi[23:16], duty_lo[23:16]}, 32'h0500);
        step(1'b1, 4'd7, 8'h09);
        chk("ar_pend3", {31'b0, pending[3]}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_lo",   32'(duty_lo), 32'h0);
        chk("ar_hi",   32'(duty_hi), 32'h0);
        chk("ar_pend", 32'(pending), 32'h0);
        chk("ar_fs",   {31'b0, failsafe}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        model_clear();
        idle(45);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
